multi_cycle_control_hs: RTL and testbench

- Parametrised successor to the team's multi-cycle MIPS control FSM; drives the shared-memory multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).
- Adds a variable-latency memory handshake (mem_ready) with a wait-state timeout.
- Adds jal/jr/jalr/xori support.
- Adds an illegal-instruction/timeout trap with a configurable halt mode, plus a retire strobe.

---
 rtl/multi_cycle_control_hs_pkg.sv | 116 +++++++++++
 rtl/multi_cycle_control_hs_mem_wait_timer.sv | 44 ++++
 rtl/multi_cycle_control_hs.sv | 228 ++++++++++++++++++++++
 tb/tb_multi_cycle_control_hs.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_hs_pkg.sv
// Shared encodings for the handshaked multi-cycle MIPS control FSM: opcodes,
// datapath mux selects, state codes, trap causes and the bundled control word.
package multi_cycle_control_hs_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_JALR = 6'h09
    } funct_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_REG    = 2'b00,
        SRC_B_FOUR   = 2'b01,
        SRC_B_IMM    = 2'b10,
        SRC_B_IMM_SH = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_REG_A  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        PC_COND_OFF = 2'b00,
        PC_COND_EQ  = 2'b01,
        PC_COND_NE  = 2'b10
    } pc_cond_e;

    typedef enum logic [1:0] {
        M2R_ALUOUT = 2'b00,
        M2R_MDR    = 2'b01,
        M2R_PC     = 2'b10
    } mem_to_reg_e;

    typedef enum logic [1:0] {
        DST_RT  = 2'b00,
        DST_RD  = 2'b01,
        DST_R31 = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_e;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEM_ADDR = 5'd3,
        S_MEM_RD   = 5'd4,
        S_MEM_WB   = 5'd5,
        S_MEM_WR   = 5'd6,
        S_R_EXEC   = 5'd7,
        S_R_WB     = 5'd8,
        S_BEQ      = 5'd9,
        S_BNE      = 5'd10,
        S_JUMP     = 5'd11,
        S_JAL      = 5'd12,
        S_JR       = 5'd13,
        S_JALR     = 5'd14,
        S_I_EXEC   = 5'd15,
        S_I_WB     = 5'd16,
        S_TRAP     = 5'd17,
        S_HALT     = 5'd18
    } state_e;

    typedef struct packed {
        pc_cond_e    pc_write_cond;
        logic        pc_write;
        logic        ior_d;
        logic        mem_read;
        logic        mem_write;
        mem_to_reg_e mem_to_reg;
        logic        ir_write;
        pc_src_e     pc_source;
        alu_op_e     alu_op;
        alu_src_b_e  alu_src_b;
        logic        alu_src_a;
        logic        reg_write;
        reg_dst_e    reg_dst;
        logic        trap;
        logic        retire;
    } ctrl_t;

    // States that talk to memory and therefore wait on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multi_cycle_control_hs_mem_wait_timer.sv
// Counts stalled cycles in a memory state and flags the last cycle allowed
// before the access is declared timed out.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned WAIT_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam bit                TO_EN   = (MEM_TIMEOUT != 0);
    localparam int unsigned       LIMIT   = TO_EN ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] LIMIT_W = WAIT_W'(LIMIT);
    localparam logic [WAIT_W-1:0] CNT_MAX = '1;

    logic [WAIT_W-1:0] count_q, count_d;

    // NOTE: every variable gets its default before any branch, so no path through
    // the block leaves count_d unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator runs processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = TO_EN && (count_q == LIMIT_W);

endmodule

// File: rtl/multi_cycle_control_hs.sv
// Multi-cycle MIPS control FSM with a mem_ready handshake, wait-state timeout,
// illegal-instruction trap and a per-instruction retire strobe.
module multi_cycle_control_hs
    import multi_cycle_control_hs_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned MEM_TIMEOUT   = 16,
    parameter int unsigned WAIT_W        = 5,
    parameter int unsigned TRAP_HALT     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [1:0] pc_write_cond,
    output logic       pc_write,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic       ir_write,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire,
    output logic [4:0] state_o
);

    localparam bit HS_EN = (MEM_HANDSHAKE != 0);

    state_e      state_q, state_d;
    trap_cause_e trap_cause_q, trap_cause_d;
    ctrl_t       ctrl;
    logic        rdy;
    logic        wait_timeout;

    assign rdy = mem_ready || !HS_EN;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .WAIT_W     (WAIT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != state_q),
        .inc    (is_mem_state(state_q) && !rdy),
        .timeout(wait_timeout)
    );

    always_comb begin
        ctrl         = '0;
        state_d      = state_q;
        trap_cause_d = trap_cause_q;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                if (rdy) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end
            end

            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct == FN_JR)        state_d = S_JR;
                        else if (funct == FN_JALR) state_d = S_JALR;
                        else                       state_d = S_R_EXEC;
                    end
                    OP_BEQ: state_d = S_BEQ;
                    OP_BNE: state_d = S_BNE;
                    OP_J:   state_d = S_JUMP;
                    OP_JAL: state_d = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: state_d = S_I_EXEC;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                state_d        = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
                if (rdy) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.retire     = 1'b1;
                state_d         = S_FETCH;
            end

            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
                if (rdy) begin
                    ctrl.retire = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_R_WB;
            end

            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DST_RD;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end

            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = (state_q == S_BEQ) ? PC_COND_EQ : PC_COND_NE;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.retire        = 1'b1;
                state_d            = S_FETCH;
            end

            // PC already holds PC+4 here, so jal/jalr link the pre-edge PC.
            S_JUMP, S_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
                ctrl.retire    = 1'b1;
                if (state_q == S_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_R31;
                    ctrl.mem_to_reg = M2R_PC;
                end
                state_d = S_FETCH;
            end

            S_JR, S_JALR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_REG_A;
                ctrl.retire    = 1'b1;
                if (state_q == S_JALR) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = DST_RD;
                    ctrl.mem_to_reg = M2R_PC;
                end
                state_d = S_FETCH;
            end

            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_IMM;
                state_d        = S_I_WB;
            end

            S_I_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
                state_d        = S_FETCH;
            end

            S_TRAP: begin
                ctrl.trap = 1'b1;
                state_d   = (TRAP_HALT != 0) ? S_HALT : S_FETCH;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_RESET;
        endcase

        // A late mem_ready on the final allowed wait cycle still completes the access.
        if (is_mem_state(state_q) && !rdy && wait_timeout) begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_write      = ctrl.pc_write;
    assign ior_d         = ctrl.ior_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign trap          = ctrl.trap;
    assign retire        = ctrl.retire;
    assign trap_cause    = trap_cause_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_multi_cycle_control_hs.sv
// Scoreboard bench: each instruction's expected end event (retire or trap, final
// control word, cycle count, cause) is queued; a monitor pops on retire/trap.
module tb_multi_cycle_control_hs;
    import multi_cycle_control_hs_pkg::*;

    localparam int T = 4;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR, C_ILL} cls_e;

    typedef struct packed {
        logic [1:0] pwc;
        logic       pw, iord, mr, mw;
        logic [1:0] m2r;
        logic       irw;
        logic [1:0] psrc, aop, bsrc;
        logic       asrc, rw;
        logic [1:0] rdst;
    } ctl_t;

    typedef struct {
        bit         is_trap;
        logic [1:0] cause;
        ctl_t       ctl;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       mem_ready = 1'b0;
    logic [1:0] pc_write_cond, mem_to_reg, pc_source, alu_op, alu_src_b, reg_dst, trap_cause;
    logic       pc_write, ior_d, mem_read, mem_write, ir_write, alu_src_a, reg_write, trap, retire;
    logic [4:0] state_o;
    ctl_t       act_ctl;

    int   errors = 0, checks = 0;
    int   lat = 0, ev_cnt = 0;
    exp_t exp_q[$];
    int   plan_q[$];

    multi_cycle_control_hs #(
        .MEM_HANDSHAKE(1), .MEM_TIMEOUT(T), .WAIT_W(5), .TRAP_HALT(1)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write_cond(pc_write_cond), .pc_write(pc_write), .ior_d(ior_d),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .alu_src_a(alu_src_a), .reg_write(reg_write),
        .reg_dst(reg_dst), .trap(trap), .trap_cause(trap_cause), .retire(retire),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign act_ctl = {pc_write_cond, pc_write, ior_d, mem_read, mem_write, mem_to_reg,
                      ir_write, pc_source, alu_op, alu_src_b, alu_src_a, reg_write, reg_dst};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Control word visible in the final cycle of each instruction class.
    function automatic ctl_t final_ctl(input cls_e c);
        ctl_t k = '0;
        case (c)
            C_LW:   begin k.rw = 1; k.m2r = 2'b01; end
            C_SW:   begin k.mw = 1; k.iord = 1; end
            C_R:    begin k.rw = 1; k.rdst = 2'b01; end
            C_I:    k.rw = 1;
            C_BEQ:  begin k.asrc = 1; k.aop = 2'b01; k.pwc = 2'b01; k.psrc = 2'b01; end
            C_BNE:  begin k.asrc = 1; k.aop = 2'b01; k.pwc = 2'b10; k.psrc = 2'b01; end
            C_J:    begin k.pw = 1; k.psrc = 2'b10; end
            C_JAL:  begin k.pw = 1; k.psrc = 2'b10; k.rw = 1; k.rdst = 2'b10; k.m2r = 2'b10; end
            C_JR:   begin k.pw = 1; k.psrc = 2'b11; end
            C_JALR: begin k.pw = 1; k.psrc = 2'b11; k.rw = 1; k.rdst = 2'b01; k.m2r = 2'b10; end
            default: k = '0;
        endcase
        return k;
    endfunction

    function automatic int base_lat(input cls_e c);
        case (c)
            C_LW:            return 5;
            C_SW, C_R, C_I:  return 4;
            default:         return 3;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pick_stall();
        int r = $urandom_range(0, 15);
        if (r < 7)   return 0;
        if (r < 14)  return $urandom_range(1, T - 1);
        if (r == 14) return T - 1;
        return T;
    endfunction

    task automatic pick_op(input cls_e c, input int force_op, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] itype [6] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        fn = 6'($urandom_range(0, 63));
        case (c)
            C_LW:   op = 6'h23;
            C_SW:   op = 6'h2B;
            C_R:    begin op = 6'h00; if (fn == 6'h08 || fn == 6'h09) fn = 6'h20; end
            C_JR:   begin op = 6'h00; fn = 6'h08; end
            C_JALR: begin op = 6'h00; fn = 6'h09; end
            C_BEQ:  op = 6'h04;
            C_BNE:  op = 6'h05;
            C_J:    op = 6'h02;
            C_JAL:  op = 6'h03;
            C_I:    op = itype[$urandom_range(0, 5)];
            default: begin
                op = 6'($urandom_range(0, 63));
                while (legal_op(op)) op = 6'($urandom_range(0, 63));
            end
        endcase
        if (force_op >= 0) op = 6'(force_op);
    endtask

    // Memory responder: answers each memory phase after the planned number of stalls.
    int waited = 0, plan = 0;
    bit act = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            act = 0;
            mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            if (!act) begin
                act = 1;
                waited = 0;
                plan = (plan_q.size() != 0) ? plan_q.pop_front() : 0;
            end
            if (waited >= plan) begin
                mem_ready = 1'b1;
                act = 0;
            end else begin
                mem_ready = 1'b0;
                waited++;
            end
        end else begin
            act = 0;
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks stall behaviour every cycle and scores each retire/trap event.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            lat = -1;
        end else begin
            lat++;
            if ((mem_read || mem_write) && !mem_ready)
                check("wait_strobes", {pc_write, ir_write, reg_write, retire, trap}, 5'b0);
            if (retire || trap) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got retire=%0b trap=%0b, expected none", retire, trap);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_trap", {retire, trap}, e.is_trap ? 2'b01 : 2'b10);
                    check("event_ctl", act_ctl, e.ctl);
                    check("event_latency", lat, e.lat);
                    check("trap_cause", trap_cause, e.cause);
                end
                lat = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        plan_q.delete();
        #1;
        check("rst_outputs", {act_ctl, retire, trap, trap_cause}, '0);
        check("rst_state", state_o, S_RESET);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 check("post_rst_state", state_o, S_RESET);
    endtask

    task automatic run_instr(input cls_e c, input int s0, input int s1, input int force_op);
        exp_t e;
        int   target;
        pick_op(c, force_op, opcode, funct);
        e.is_trap = 0;
        e.cause   = 2'b00;
        e.ctl     = '0;
        plan_q.push_back(s0);
        if (s0 >= T) begin
            e.is_trap = 1; e.cause = 2'b10; e.lat = T + 1;
        end else if (c == C_ILL) begin
            e.is_trap = 1; e.cause = 2'b01; e.lat = 3 + s0;
        end else if ((c == C_LW || c == C_SW) && s1 >= T) begin
            plan_q.push_back(s1);
            e.is_trap = 1; e.cause = 2'b10; e.lat = s0 + T + 4;
        end else begin
            if (c == C_LW || c == C_SW) plan_q.push_back(s1);
            e.ctl = final_ctl(c);
            e.lat = base_lat(c) + s0 + ((c == C_LW || c == C_SW) ? s1 : 0);
        end
        exp_q.push_back(e);
        target = ev_cnt + 1;
        for (int i = 0; i < 200 && ev_cnt < target; i++) begin
            @(negedge clk);
            #1;
        end
        check("event_arrived", ev_cnt >= target, 1'b1);
        if (ev_cnt < target) begin
            do_reset();
        end else if (e.is_trap) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1 check("halt_parked", {state_o, retire, trap, trap_cause, act_ctl},
                         {S_HALT, 1'b0, 1'b0, e.cause, 19'b0});
            end
            do_reset();
        end
    endtask

    initial begin
        do_reset();
        run_instr(C_LW, 0, 0, -1);
        run_instr(C_SW, 0, 3, -1);
        run_instr(C_JAL, 0, 0, -1);
        run_instr(C_JALR, 0, 0, -1);
        run_instr(C_ILL, 0, 0, 'h3F);
        run_instr(C_R, T, 0, -1);
        run_instr(C_R, T - 1, 0, -1);
        run_instr(C_LW, 1, T, -1);
        run_instr(C_SW, 0, T, -1);
        run_instr(C_I, 2, 0, 'h0E);
        for (int n = 0; n < 120; n++) begin
            cls_e c = cls_e'($urandom_range(0, 10));
            int   a = pick_stall();
            int   b = pick_stall();
            run_instr(c, a, b, -1);
        end

        // Asynchronous reset in the middle of a stalled load.
        opcode = 6'h23;
        plan_q.push_back(0);
        plan_q.push_back(3);
        for (int i = 0; i < 20 && !(mem_read && ior_d); i++) begin
            @(negedge clk);
            #1;
        end
        check("reached_mem_rd", state_o, S_MEM_RD);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {act_ctl, retire, trap, trap_cause}, '0);
        check("async_rst_state", state_o, S_RESET);
        plan_q.delete();
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 check("release_reset_state", state_o, S_RESET);
        @(negedge clk);
        #1 check("release_fetch", {state_o, mem_read}, {S_FETCH, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
